instr_enc_loader: RTL and testbench

INSTR_ENC_LOADER -- requirements
Module: instr_enc_loader

---
 rtl/isa_pkg.sv | 72 +++++++
 rtl/instr_enc_loader_if.sv | 30 +++
 rtl/enc_fifo2.sv | 58 +++++
 rtl/instr_enc_loader.sv | 114 +++++++++++
 tb/tb_instr_enc_loader.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions: command op codes, 6-bit instruction opcodes, loader
// state encoding and the combinational instruction encoder.
package isa_pkg;

    typedef enum logic [3:0] {
        OP_RT   = 4'd0,
        OP_ADDI = 4'd1,
        OP_ANDI = 4'd2,
        OP_LW   = 4'd3,
        OP_SW   = 4'd4,
        OP_J    = 4'd5,
        OP_JAL  = 4'd6,
        OP_JR   = 4'd7,
        OP_BEQ  = 4'd8,
        OP_BNE  = 4'd9
    } op_e;

    localparam logic [5:0] OPC_RT   = 6'b000000;
    localparam logic [5:0] OPC_ADDI = 6'b001000;
    localparam logic [5:0] OPC_ANDI = 6'b001100;
    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;
    localparam logic [5:0] OPC_J    = 6'b000010;
    localparam logic [5:0] OPC_JAL  = 6'b000011;
    localparam logic [5:0] OPC_JR   = 6'b110011;
    localparam logic [5:0] OPC_BEQ  = 6'b000100;
    localparam logic [5:0] OPC_BNE  = 6'b000101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic        legal;
        logic [31:0] word;
    } enc_t;

    // FIFO entry is {address, instruction word}
    localparam int ENTRY_W = 40;

    function automatic enc_t encode_instr(
        input logic [3:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [5:0]  funct,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        enc_t r;
        r.legal = 1'b1;
        r.word  = '0;
        case (op)
            OP_RT:   r.word = {OPC_RT, rs, rt, rd, 5'b0, funct};
            OP_ADDI: r.word = {OPC_ADDI, rs, rt, imm};
            OP_ANDI: r.word = {OPC_ANDI, rs, rt, imm};
            OP_LW:   r.word = {OPC_LW, rs, rt, imm};
            OP_SW:   r.word = {OPC_SW, rs, rt, imm};
            OP_BEQ:  r.word = {OPC_BEQ, rs, rt, imm};
            OP_BNE:  r.word = {OPC_BNE, rs, rt, imm};
            OP_J:    r.word = {OPC_J, target};
            OP_JAL:  r.word = {OPC_JAL, target};
            OP_JR:   r.word = {OPC_JR, rs, 21'b0};
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instr_enc_loader_if.sv
// Command-in and memory-write-out handshake bundle of the instruction loader.
interface instr_enc_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;

    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_addr;
    logic [31:0] out_data;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm, in_target, in_last,
        output out_ready,
        input  in_ready, out_valid, out_addr, out_data
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm, in_target, in_last,
        input  out_ready,
        output in_ready, out_valid, out_addr, out_data
    );
endinterface

// File: rtl/enc_fifo2.sv
// Two-entry register FIFO; head is visible the cycle after the first push.
module enc_fifo2 #(
    parameter int W = 40
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         valid,
    output logic [W-1:0] head
);
    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic       do_push;
    logic       do_pop;

    assign valid   = (count_reg != 2'd0);
    assign full    = (count_reg == 2'd2);
    assign do_pop  = pop & valid;
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [W-1:0] entry_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg <= push_data;
                end
            end
        end
    endgenerate

    assign head = !valid      ? '0 :
                  rd_ptr_reg  ? g_entry[1].entry_reg : g_entry[0].entry_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
            if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/instr_enc_loader.sv
// Session-based loader: encodes command stream into instruction words and
// writes them to consecutive instruction-memory addresses.
module instr_enc_loader
    import isa_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [7:0]          base_addr,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                ovf,
    output logic [8:0]          word_cnt,
    instr_enc_loader_if.slave   io
);
    state_e      state_reg;
    logic [7:0]  addr_ctr_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        err_reg;
    logic        ovf_reg;
    logic [8:0]  word_cnt_reg;

    enc_t        enc;
    logic        accept;
    logic        push;
    logic        fifo_full;
    logic        fifo_valid;
    logic [ENTRY_W-1:0] fifo_head;
    logic        wr_handshake;
    logic        at_top;

    assign enc = encode_instr(io.in_op, io.in_rs, io.in_rt, io.in_rd,
                              io.in_funct, io.in_imm, io.in_target);

    assign io.in_ready   = (state_reg == ST_LOAD) & ~fifo_full;
    assign accept        = io.in_valid & io.in_ready;
    assign push          = accept & enc.legal;
    assign at_top        = (addr_ctr_reg == 8'hFF);
    assign wr_handshake  = fifo_valid & io.out_ready;

    enc_fifo2 #(.W(ENTRY_W)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({addr_ctr_reg, enc.word}),
        .pop       (io.out_ready),
        .full      (fifo_full),
        .valid     (fifo_valid),
        .head      (fifo_head)
    );

    assign io.out_valid = fifo_valid;
    assign io.out_addr  = fifo_head[39:32];
    assign io.out_data  = fifo_head[31:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            addr_ctr_reg <= 8'h00;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            ovf_reg      <= 1'b0;
            word_cnt_reg <= 9'd0;
        end else begin
            if (wr_handshake) word_cnt_reg <= word_cnt_reg + 9'd1;
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        state_reg    <= ST_LOAD;
                        addr_ctr_reg <= base_addr;
                        busy_reg     <= 1'b1;
                        err_reg      <= 1'b0;
                        ovf_reg      <= 1'b0;
                        word_cnt_reg <= 9'd0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (!enc.legal) begin
                            err_reg <= 1'b1;
                        end else if (!at_top) begin
                            addr_ctr_reg <= addr_ctr_reg + 8'd1;
                        end
                        // The last address was just used: stop instead of wrapping
                        if (enc.legal && at_top && !io.in_last) ovf_reg <= 1'b1;
                        if (io.in_last || (enc.legal && at_top)) state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!fifo_valid) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    done_reg  <= 1'b0;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    assign ovf      = ovf_reg;
    assign word_cnt = word_cnt_reg;
endmodule

// File: tb/tb_instr_enc_loader.sv
// Directed bench for instr_enc_loader: stimulus pushes expected writes into a
// scoreboard queue, a negedge monitor checks every memory-write handshake.
module tb_instr_enc_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] base_addr = 8'h00;
    logic       busy, done, err, ovf;
    logic [8:0] word_cnt;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int done_snap = 0;
    logic [7:0] exp_addr;
    logic [39:0] sb[$];

    instr_enc_loader_if io ();

    instr_enc_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .ovf       (ovf),
        .word_cnt  (word_cnt),
        .io        (io.slave)
    );

    always #5 clk = ~clk;

    // Monitor: write handshakes, hold-while-stalled, done pulses
    logic        prev_stall = 1'b0;
    logic        prev_done = 1'b0;
    logic [7:0]  prev_addr = 8'h00;
    logic [31:0] prev_data = 32'h0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!(io.out_valid && io.out_addr == prev_addr && io.out_data == prev_data)) begin
                    errors++;
                    $display("FAIL hold: valid=%0b addr=%02h data=%08h, required valid=1 addr=%02h data=%08h",
                             io.out_valid, io.out_addr, io.out_data, prev_addr, prev_data);
                end
            end
            if (io.out_valid && io.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL write: unexpected addr=%02h data=%08h, required no write",
                             io.out_addr, io.out_data);
                end else begin
                    logic [39:0] e;
                    e = sb.pop_front();
                    if ({io.out_addr, io.out_data} !== e) begin
                        errors++;
                        $display("FAIL write: addr=%02h data=%08h, required addr=%02h data=%08h",
                                 io.out_addr, io.out_data, e[39:32], e[31:0]);
                    end else begin
                        $display("write addr=%02h data=%08h ok", io.out_addr, io.out_data);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                checks++;
                if (prev_done) begin
                    errors++;
                    $display("FAIL done_pulse: done high 2 cycles, required 1");
                end
            end
            prev_stall = io.out_valid && !io.out_ready;
            prev_addr  = io.out_addr;
            prev_data  = io.out_data;
            prev_done  = done;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 io.out_ready = r;
    endtask

    task automatic do_start(input logic [7:0] b);
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        @(negedge clk);
        start = 1'b0;
        exp_addr = b;
        done_snap = done_cnt;
    endtask

    // Offer one command; exp_acc says whether it must be taken within 'bound' cycles
    task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
                        input logic [25:0] target, input logic last, input logic [31:0] exp_data,
                        input bit legal, input bit track, input bit exp_acc, input int bound);
        bit acc = 0;
        @(negedge clk);
        io.in_valid = 1'b1; io.in_op = op; io.in_rs = rs; io.in_rt = rt; io.in_rd = rd;
        io.in_funct = funct; io.in_imm = imm; io.in_target = target; io.in_last = last;
        for (int i = 0; i < bound; i++) begin
            if (io.in_ready) begin
                @(posedge clk);
                acc = 1;
                break;
            end
            @(negedge clk);
        end
        #1 io.in_valid = 1'b0;
        checks++;
        if (acc != exp_acc) begin
            errors++;
            $display("FAIL accept op=%0d: accepted=%0b, required %0b", op, acc, exp_acc);
        end
        if (acc && legal) begin
            if (track) sb.push_back({exp_addr, exp_data});
            exp_addr = exp_addr + 8'd1;
        end
        $display("cmd op=%0d last=%0b accepted=%0b", op, last, acc);
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (done_cnt == done_snap && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt == done_snap) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", bound);
        end
        @(negedge clk);
        chk("busy_after_done", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        io.in_valid = 1'b0; io.in_op = 4'd0; io.in_rs = 5'd0; io.in_rt = 5'd0; io.in_rd = 5'd0;
        io.in_funct = 6'd0; io.in_imm = 16'd0; io.in_target = 26'd0; io.in_last = 1'b0;
        io.out_ready = 1'b1;
        exp_addr = 8'h00;
        #12;
        chk("rst_out_valid", {31'b0, io.out_valid}, 0);
        chk("rst_in_ready", {31'b0, io.in_ready}, 0);
        chk("rst_out_data", io.out_data, 0);
        chk("rst_flags", {busy, done, err, ovf, io.out_addr}, 0);
        chk("rst_word_cnt", {23'b0, word_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // in_valid in IDLE is ignored
        io.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_in_ready", {31'b0, io.in_ready}, 0);
        chk("idle_out_valid", {31'b0, io.out_valid}, 0);
        io.in_valid = 1'b0;

        // Single addi session
        do_start(8'h10);
        chk("busy_load", {31'b0, busy}, 1);
        send(4'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b1, 32'h20220005, 1, 1, 1, 10);
        wait_done(20);
        chk("s1_word_cnt", {23'b0, word_cnt}, 1);
        chk("s1_err", {31'b0, err}, 0);

        // RT then j
        do_start(8'h30);
        send(4'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'd0, 1'b0, 32'h00221820, 1, 1, 1, 10);
        send(4'd5, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000040, 1'b1, 32'h08000040, 1, 1, 1, 10);
        wait_done(20);
        chk("s2_word_cnt", {23'b0, word_cnt}, 2);

        // Backpressure: two accepted, third blocked until out_ready returns
        set_ready(1'b0);
        do_start(8'h40);
        send(4'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b0, 32'h20220005, 1, 1, 1, 10);
        send(4'd3, 5'd3, 5'd4, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b0, 32'h8C640010, 1, 1, 1, 10);
        send(4'd4, 5'd5, 5'd6, 5'd0, 6'd0, 16'hFFFC, 26'd0, 1'b1, 32'hACA6FFFC, 1, 1, 0, 4);
        chk("stall_in_ready", {31'b0, io.in_ready}, 0);
        set_ready(1'b1);
        send(4'd4, 5'd5, 5'd6, 5'd0, 6'd0, 16'hFFFC, 26'd0, 1'b1, 32'hACA6FFFC, 1, 1, 1, 10);
        wait_done(20);
        chk("s3_word_cnt", {23'b0, word_cnt}, 3);

        // Illegal op between two legal ones
        do_start(8'h50);
        send(4'd3, 5'd3, 5'd4, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b0, 32'h8C640010, 1, 1, 1, 10);
        send(4'd12, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1111, 26'd1, 1'b0, 32'h0, 0, 1, 1, 10);
        send(4'd4, 5'd5, 5'd6, 5'd0, 6'd0, 16'hFFFC, 26'd0, 1'b1, 32'hACA6FFFC, 1, 1, 1, 10);
        wait_done(20);
        chk("s4_err", {31'b0, err}, 1);
        chk("s4_word_cnt", {23'b0, word_cnt}, 2);
        chk("s4_ovf", {31'b0, ovf}, 0);

        // Address exhaustion at 0xFF
        do_start(8'hFE);
        send(4'd2, 5'd7, 5'd8, 5'd0, 6'd0, 16'h00FF, 26'd0, 1'b0, 32'h30E800FF, 1, 1, 1, 10);
        send(4'd6, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h3FFFFFF, 1'b0, 32'h0FFFFFFF, 1, 1, 1, 10);
        send(4'd9, 5'd9, 5'd10, 5'd0, 6'd0, 16'h0003, 26'd0, 1'b0, 32'h152A0003, 1, 1, 0, 3);
        wait_done(20);
        chk("s5_ovf", {31'b0, ovf}, 1);
        chk("s5_err", {31'b0, err}, 0);
        chk("s5_word_cnt", {23'b0, word_cnt}, 2);
        // Flags hold in IDLE
        repeat (3) @(negedge clk);
        chk("s5_ovf_hold", {31'b0, ovf}, 1);

        // Remaining encodings: jr, beq, bne
        do_start(8'h20);
        send(4'd7, 5'd31, 5'd0, 5'd0, 6'd0, 16'h0, 26'd0, 1'b0, 32'hCFE00000, 1, 1, 1, 10);
        send(4'd8, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0, 32'h1022FFFF, 1, 1, 1, 10);
        send(4'd9, 5'd9, 5'd10, 5'd0, 6'd0, 16'h0003, 26'd0, 1'b1, 32'h152A0003, 1, 1, 1, 10);
        wait_done(20);
        chk("s6_word_cnt", {23'b0, word_cnt}, 3);
        chk("s6_ovf_cleared", {31'b0, ovf}, 0);

        // Reset with two pending entries
        set_ready(1'b0);
        do_start(8'h60);
        send(4'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b0, 32'h20220005, 1, 0, 1, 10);
        send(4'd3, 5'd3, 5'd4, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b0, 32'h8C640010, 1, 0, 1, 10);
        @(negedge clk);
        chk("pre_rst_out_valid", {31'b0, io.out_valid}, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", {31'b0, io.out_valid}, 0);
        chk("rst_mid_busy", {31'b0, busy}, 0);
        chk("rst_mid_in_ready", {31'b0, io.in_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        io.out_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_out_valid", {31'b0, io.out_valid}, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
